rail_block_signaling: RTL

- Parametrised multi-block automatic signalling controller; successor to the single-sensor 4-signal controller.
- Manages N_BLK consecutive track blocks; each block has a raw occupancy sensor, and signal i protects entry to block i.
- Adds per-block debounce, 4-aspect look-ahead, one-step-at-a-time timed aspect upgrades, train-sequence fault detection and global override.
- Sits between the trackside sensor inputs and the lamp drivers.

---
 rtl/rail_block_signaling.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rail_block_signaling.sv
// Multi-block signalling controller: per-block debounce, 4-aspect look-ahead, timed one-step upgrades, sequence fault.
// Latency: raw sensor to aspect DEB_CYC+1 edges, occ_db to downgrade 1 edge; no backpressure, all outputs registered.
module rail_block_signaling #(
  parameter int N_BLK    = 4,
  parameter int DEB_CYC  = 3,
  parameter int STEP_CYC = 8,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [N_BLK-1:0]   occ_in,
  input  logic               override,
  input  logic               fault_clr,
  output logic [2*N_BLK-1:0] aspect,
  output logic [N_BLK-1:0]   occ_db,
  output logic               fault
);

  typedef enum logic [1:0] {
    RED  = 2'b00,
    YEL  = 2'b01,
    DYEL = 2'b10,
    GRN  = 2'b11
  } aspect_t;

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] deb_cnt  [N_BLK];
  logic [CNT_W-1:0] step_cnt [N_BLK];
  aspect_t          cur      [N_BLK];
  aspect_t          tgt      [N_BLK];
  logic [N_BLK-1:0] occ_prev;
  logic [N_BLK+1:0] occ_ext;
  logic             seq_err;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      occ_db <= '0;
      for (int i = 0; i < N_BLK; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BLK; i++) begin
        if (occ_in[i] == occ_db[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          occ_db[i]  <= occ_in[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // A train may only appear in block i after block i-1 was already occupied; block 0 is the entry point.
  always_comb begin
    seq_err = 1'b0;
    for (int i = 1; i < N_BLK; i++) begin
      if (occ_db[i] && !occ_prev[i] && !occ_prev[i-1]) seq_err = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      occ_prev <= '0;
      fault    <= 1'b0;
    end else begin
      occ_prev <= occ_db;
      if (seq_err) begin
        fault <= 1'b1;
      end else if (fault_clr && (occ_db == '0)) begin
        fault <= 1'b0;
      end
    end
  end

  // Two zero pad bits past the last block read as clear track beyond the controlled section.
  assign occ_ext = {2'b00, occ_db};

  always_comb begin
    for (int i = 0; i < N_BLK; i++) begin
      tgt[i] = GRN;
      if (occ_ext[i] || fault || override) begin
        tgt[i] = RED;
      end else if (occ_ext[i+1]) begin
        tgt[i] = YEL;
      end else if (occ_ext[i+2]) begin
        tgt[i] = DYEL;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < N_BLK; i++) begin
        cur[i]      <= RED;
        step_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BLK; i++) begin
        if (tgt[i] < cur[i]) begin
          cur[i]      <= tgt[i];
          step_cnt[i] <= '0;
        end else if (tgt[i] == cur[i]) begin
          step_cnt[i] <= '0;
        end else if (step_cnt[i] == STEP_MAX) begin
          cur[i]      <= aspect_t'(cur[i] + 2'd1);
          step_cnt[i] <= '0;
        end else begin
          step_cnt[i] <= step_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    aspect = '0;
    for (int i = 0; i < N_BLK; i++) aspect[2*i +: 2] = cur[i];
  end

endmodule
